load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequences every data-side access from the core into the word-organised data memory. The data memory has a one-cycle synchronous read and a write that takes priority over read. This block sits directly upstream of it. It converts byte addresses to word addresses and performs sign/zero-extension for LB/LH/LBU/LHU. It implements SB/SH as read-modify-write and flags misaligned, out-of-range or illegal accesses without touching memory.

## Interface
- ADDR_W, 10, word-address bits implemented in data memory (1024 words)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents an access
- req_ready  out  1  high only in IDLE; access accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  32  byte address
- req_wdata  in  32  store data (bytes/halves taken from LSBs)
- rsp_valid  out  1  one-cycle pulse, access complete
- rsp_rdata  out  32  extended load data; 0 for stores and errors; held until next rsp_valid
- rsp_err  out  1  qualified by rsp_valid; misaligned/out-of-range/illegal funct3
- dm_address  out  32  word address to data memory
- dm_data_in  out  32  write data to data memory
- dm_write_enable  out  1  memory write strobe
- dm_read_enable  out  1  memory read strobe
- dm_data_out  in  32  memory read data, valid the cycle after dm_read_enable

## Operation
- funct3: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only); all others illegal.
- Error on accept if any of the following holds:
  - funct3 is illegal.
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - req_addr[31:ADDR_W+2]≠0.
- Little-endian lanes:
  - Byte k=addr[1:0] occupies bits [8k+7:8k].
  - Half h=addr[1] occupies bits [16h+15:16h].
- Loads: B/H sign-extend, BU/HU zero-extend, W passes through.
- Sub-word stores: the word is read and the lane replaced with req_wdata[7:0] or [15:0]. The other lanes are preserved.
- FSM states:
  - IDLE: req_ready=1. On accept, latch the request. Go to RESP on error, WRITE on SW, READ otherwise.
  - READ: dm_read_enable=1, then go to WAIT.
  - WAIT: capture dm_data_out. For a load, extract into the rsp_rdata register and go to RESP. For SB/SH, merge into the write register and go to WRITE.
  - WRITE: dm_write_enable=1, dm_data_in=write register, then go to RESP.
  - RESP: rsp_valid=1, then go to IDLE.
- dm_address={zeros, addr[ADDR_W+1:2]} in all non-IDLE states; 0 in IDLE.
- dm_data_in is 0 outside WRITE. dm_read_enable and dm_write_enable are never high together.
- Errors perform no memory access.

## Timing
- Cycle 0 is the accept cycle. Latencies, with rsp_valid high in the cycle given:
  - Error: cycle 1.
  - SW: written at end of cycle 1; rsp_valid cycle 2.
  - Load: read issued cycle 1, data cycle 2, rsp_valid cycle 3.
  - SB/SH: read issued cycle 1, data cycle 2, written at end of cycle 3; rsp_valid cycle 4.
- Back-to-back: the earliest next accept is the cycle after RESP. req_valid outside IDLE is ignored and does not disturb the latched request.
- Reset values: state IDLE, req_ready=1 after deassertion, all other outputs and internal registers 0.
- Reset mid-operation:
  - All strobes drop immediately (asynchronous) and no write completes.
  - An SB/SH interrupted before WRITE leaves memory unchanged.
  - No rsp_valid is issued for the aborted access.

## Structure
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum {IDLE, READ, WAIT, WRITE, RESP}
- One combinational sub-module, lsu_lane_align, performs lane extraction with sign/zero extension (load path) and lane merge (store path). It is driven by funct3, addr[1:0], the memory word and the store data.
- The FSM, request registers and error decode stay in load_store_unit.

## Test plan
- SW addr 0x0000_0010, data 0xDEADBEEF:
  - dm_address=4, dm_write_enable in cycle 1 only.
  - rsp_valid cycle 2, rsp_err=0.
  - LW of the same address returns 0xDEADBEEF in cycle 3.
- With word 4=0xDEADBEEF:
  - LB 0x13 returns 0xFFFFFFDE.
  - LBU 0x13 returns 0x000000DE.
  - LH 0x10 returns 0xFFFFBEEF.
  - LHU 0x12 returns 0x0000DEAD.
- SB 0x11 data 0x55 on word 0xDEADBEEF:
  - Read cycle 1, write cycle 3 of 0xDEAD55EF, rsp cycle 4.
  - SH 0x12 data 0x1234 then writes 0x123455EF.
- Each of the following gives rsp_valid+rsp_err in cycle 1 with no dm strobes:
  - LH 0x11
  - LW 0x12
  - SW 0x0000_1000 (out of range)
  - funct3=011
  - store with funct3=100
- Assert rst during WAIT of an SB: strobes drop at once, no rsp_valid, and memory word is unchanged on later LW.
- Hold req_valid high with alternating requests: each accept occurs only in IDLE, the latched request is unaffected by mid-operation changes, and the response order matches the accept order.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: data-memory geometry,
// RISC-V load/store funct3 encodings and the sequencing state encoding.
package lsu_pkg;

   localparam int DM_ADDR_W = 10;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// slave is the view of the load/store unit, master the view of its environment
// (the core issuing requests plus the data memory answering reads).
interface load_store_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic [31:0] dm_address;
   logic [31:0] dm_data_in;
   logic        dm_write_enable;
   logic        dm_read_enable;
   logic [31:0] dm_data_out;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, dm_data_out,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             dm_address, dm_data_in, dm_write_enable, dm_read_enable
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_data_out,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             dm_address, dm_data_in, dm_write_enable, dm_read_enable
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling for the load/store unit. Load path extracts the
// addressed lane and sign/zero extends it; store path replaces the addressed
// lane of the memory word with the low bits of the store data.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] mem_word_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merge_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Load path: pick the lane, then extend according to funct3.
   always_comb begin
      byte_sel = mem_word_i[7:0];
      case (addr_lo_i)
         2'd0:    byte_sel = mem_word_i[7:0];
         2'd1:    byte_sel = mem_word_i[15:8];
         2'd2:    byte_sel = mem_word_i[23:16];
         default: byte_sel = mem_word_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

      load_data_o = 32'd0;
      case (funct3_i)
         F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_W:    load_data_o = mem_word_i;
         F3_BU:   load_data_o = {24'd0, byte_sel};
         F3_HU:   load_data_o = {16'd0, half_sel};
         default: load_data_o = 32'd0;
      endcase
   end

   // Store path: keep the untouched lanes of the memory word.
   always_comb begin
      merge_data_o = mem_word_i;
      case (funct3_i)
         F3_B: begin
            case (addr_lo_i)
               2'd0:    merge_data_o[7:0]   = store_data_i[7:0];
               2'd1:    merge_data_o[15:8]  = store_data_i[7:0];
               2'd2:    merge_data_o[23:16] = store_data_i[7:0];
               default: merge_data_o[31:24] = store_data_i[7:0];
            endcase
         end
         F3_H: begin
            if (addr_lo_i[1]) merge_data_o[31:16] = store_data_i[15:0];
            else              merge_data_o[15:0]  = store_data_i[15:0];
         end
         default: merge_data_o = store_data_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a word-organised data memory with a
// one-cycle synchronous read. Sub-word stores are read-modify-write; faulty
// requests are answered with an error and never reach memory.
//
//   state | meaning
//   IDLE  | ready for a request, memory bus quiet
//   READ  | read strobe to memory
//   WAIT  | memory word arrives; extract (load) or merge (SB/SH)
//   WRITE | write strobe with the write register
//   RESP  | one-cycle response to the core
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.slave  bus
);

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [2:0]          f3_q, f3_d;
   logic [ADDR_W+1:0]   addr_q, addr_d;
   logic                err_q, err_d;
   logic [31:0]         wbuf_q, wbuf_d;
   logic [31:0]         rdata_q, rdata_d;

   logic                accept;
   logic                f3_illegal;
   logic                misaligned;
   logic                out_of_range;
   logic                req_err;
   logic [31:0]         load_data;
   logic [31:0]         merge_data;

   // Request-time error decode; stores only allow B/H/W.
   always_comb begin
      f3_illegal = 1'b1;
      case (bus.req_funct3)
         F3_B, F3_H, F3_W: f3_illegal = 1'b0;
         F3_BU, F3_HU:     f3_illegal = bus.req_we;
         default:          f3_illegal = 1'b1;
      endcase
      misaligned = ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0])
                || ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
      out_of_range = (bus.req_addr[31:ADDR_W+2] != '0);
      req_err = f3_illegal || misaligned || out_of_range;
   end

   assign accept = bus.req_valid && (state_q == IDLE);

   // wbuf_q holds the latched store data and, after WAIT, the merged word.
   lsu_lane_align u_lane_align (
      .funct3_i     (f3_q),
      .addr_lo_i    (addr_q[1:0]),
      .mem_word_i   (bus.dm_data_out),
      .store_data_i (wbuf_q),
      .load_data_o  (load_data),
      .merge_data_o (merge_data)
   );

   // Next-state and register updates for the access sequence.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      err_d   = err_q;
      wbuf_d  = wbuf_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d   = bus.req_we;
               f3_d   = bus.req_funct3;
               addr_d = bus.req_addr[ADDR_W+1:0];
               err_d  = req_err;
               wbuf_d = bus.req_wdata;
               if (req_err) begin
                  rdata_d = 32'd0;
                  state_d = RESP;
               end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ:  state_d = WAIT;
         WAIT: begin
            if (we_q) begin
               wbuf_d  = merge_data;
               state_d = WRITE;
            end else begin
               rdata_d = load_data;
               state_d = RESP;
            end
         end
         WRITE: begin
            rdata_d = 32'd0;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and request registers; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         err_q   <= 1'b0;
         wbuf_q  <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         wbuf_q  <= wbuf_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.req_ready       = (state_q == IDLE);
   assign bus.dm_read_enable  = (state_q == READ);
   assign bus.dm_write_enable = (state_q == WRITE);
   assign bus.dm_address      = (state_q == IDLE) ? 32'd0
                                                  : {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
   assign bus.dm_data_in      = (state_q == WRITE) ? wbuf_q : 32'd0;
   assign bus.rsp_valid       = (state_q == RESP);
   assign bus.rsp_err         = (state_q == RESP) && err_q;
   assign bus.rsp_rdata       = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected responses,
// a negedge monitor pops and compares them against rsp_valid/rsp_err/rsp_rdata
// and the cycle in which the response is due.
module tb_load_store_unit;
   import lsu_pkg::*;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
      int          tag;
   } exp_t;

   typedef struct packed {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  lat;
   } vec_t;

   logic clk;
   logic rst;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   load_store_unit_if ifc ();

   load_store_unit #(.ADDR_W(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   logic [31:0] mem [0:1023];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // data memory model: synchronous read, write has priority
   always @(posedge clk) begin
      if (ifc.dm_write_enable) mem[ifc.dm_address[9:0]] <= ifc.dm_data_in;
      else if (ifc.dm_read_enable) ifc.dm_data_out <= mem[ifc.dm_address[9:0]];
   end

   // response monitor
   always @(negedge clk) begin
      exp_t e;
      if (ifc.dm_read_enable || ifc.dm_write_enable) begin
         checks++;
         if (ifc.dm_read_enable && ifc.dm_write_enable) begin
            errors++;
            $display("FAIL strobe_excl cyc %0d: read and write strobes both high", cyc);
         end
      end
      if (ifc.rsp_valid) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected cyc %0d: got err %b rdata %h, none expected",
                     cyc, ifc.rsp_err, ifc.rsp_rdata);
         end else begin
            e = sb_q.pop_front();
            if (ifc.rsp_err !== e.err || ifc.rsp_rdata !== e.rdata || cyc != e.cyc) begin
               errors++;
               $display("FAIL rsp_req%0d: got err %b rdata %h cyc %0d, want err %b rdata %h cyc %0d",
                        e.tag, ifc.rsp_err, ifc.rsp_rdata, cyc, e.err, e.rdata, e.cyc);
            end
         end
      end
   end

   task automatic drive_req(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
      ifc.req_valid  = 1'b1;
      ifc.req_we     = we;
      ifc.req_funct3 = f3;
      ifc.req_addr   = addr;
      ifc.req_wdata  = wdata;
   endtask

   task automatic do_req(input int tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input logic [31:0] exp_wr, input int lat);
      exp_t       e;
      logic [7:0] rdm, wrm, exp_rdm, exp_wrm;
      logic       bus_ok;
      logic [31:0] exp_adr;
      exp_adr = {22'd0, addr[11:2]};
      @(negedge clk);
      checks++;
      if (ifc.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req%0d_ready: got %b want 1", tag, ifc.req_ready);
      end
      drive_req(we, f3, addr, wdata);
      e.err = exp_err; e.rdata = exp_rdata; e.cyc = cyc + lat; e.tag = tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      ifc.req_valid = 1'b0;
      rdm = 8'd0; wrm = 8'd0; bus_ok = 1'b1;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (ifc.dm_read_enable) begin
            rdm[c] = 1'b1;
            if (ifc.dm_address !== exp_adr) bus_ok = 1'b0;
         end
         if (ifc.dm_write_enable) begin
            wrm[c] = 1'b1;
            if (ifc.dm_address !== exp_adr || ifc.dm_data_in !== exp_wr) bus_ok = 1'b0;
         end else if (ifc.dm_data_in !== 32'd0) begin
            bus_ok = 1'b0;
         end
      end
      exp_rdm = (lat >= 3) ? 8'b0000_0010 : 8'b0000_0000;
      exp_wrm = (lat == 2) ? 8'b0000_0010 : (lat == 4) ? 8'b0000_1000 : 8'b0000_0000;
      checks++;
      if (rdm !== exp_rdm) begin
         errors++;
         $display("FAIL req%0d_read_cycles: got %b want %b", tag, rdm, exp_rdm);
      end
      checks++;
      if (wrm !== exp_wrm) begin
         errors++;
         $display("FAIL req%0d_write_cycles: got %b want %b", tag, wrm, exp_wrm);
      end
      checks++;
      if (!bus_ok) begin
         errors++;
         $display("FAIL req%0d_dm_bus: got address/data off, want addr %h wdata %h", tag, exp_adr, exp_wr);
      end
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL req%0d_rsp_timeout: got %0d pending, want 0", tag, sb_q.size());
         sb_q.delete();
      end
   endtask

   // start a sub-word store and reset it in cycle at_cyc (2 = WAIT, 3 = WRITE)
   task automatic reset_during(input int tag, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int at_cyc);
      @(negedge clk);
      drive_req(1'b1, f3, addr, wdata);
      @(posedge clk);
      #1;
      ifc.req_valid = 1'b0;
      repeat (at_cyc) @(negedge clk);
      checks++;
      if (ifc.dm_write_enable !== (at_cyc == 3)) begin
         errors++;
         $display("FAIL rst%0d_pre_write_en: got %b want %b", tag, ifc.dm_write_enable, at_cyc == 3);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (ifc.dm_read_enable !== 1'b0 || ifc.dm_write_enable !== 1'b0 || ifc.rsp_valid !== 1'b0 ||
          ifc.dm_address !== 32'd0 || ifc.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst%0d_abort: got rd %b wr %b rsp %b adr %h rdy %b, want 0 0 0 0 1", tag,
                  ifc.dm_read_enable, ifc.dm_write_enable, ifc.rsp_valid, ifc.dm_address, ifc.req_ready);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   vec_t b2b[7];

   initial begin
      int knext;
      int i;
      int g;
      int guard;
      exp_t e;

      rst = 1'b1;
      ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_funct3 = 3'd0;
      ifc.req_addr = 32'd0; ifc.req_wdata = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (ifc.req_ready !== 1'b1 || ifc.rsp_valid !== 1'b0 || ifc.rsp_err !== 1'b0 ||
          ifc.rsp_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_rsp: got rdy %b vld %b err %b rdata %h, want 1 0 0 0",
                  ifc.req_ready, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata);
      end
      checks++;
      if (ifc.dm_read_enable !== 1'b0 || ifc.dm_write_enable !== 1'b0 ||
          ifc.dm_address !== 32'd0 || ifc.dm_data_in !== 32'd0) begin
         errors++;
         $display("FAIL reset_dm: got rd %b wr %b adr %h din %h, want all 0",
                  ifc.dm_read_enable, ifc.dm_write_enable, ifc.dm_address, ifc.dm_data_in);
      end

      //     tag we    f3    addr           wdata          err   rdata          write data     lat
      do_req(1,  1'b1, F3_W,  32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 32'hDEADBEEF, 2);
      do_req(2,  1'b0, F3_W,  32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0,        3);
      do_req(3,  1'b0, F3_B,  32'h0000_0013, 32'h0,        1'b0, 32'hFFFFFFDE, 32'h0,        3);
      do_req(4,  1'b0, F3_BU, 32'h0000_0013, 32'h0,        1'b0, 32'h000000DE, 32'h0,        3);
      do_req(5,  1'b0, F3_H,  32'h0000_0010, 32'h0,        1'b0, 32'hFFFFBEEF, 32'h0,        3);
      do_req(6,  1'b0, F3_HU, 32'h0000_0012, 32'h0,        1'b0, 32'h0000DEAD, 32'h0,        3);
      do_req(7,  1'b1, F3_B,  32'h0000_0011, 32'hFFFFFF55, 1'b0, 32'h0000_0000, 32'hDEAD55EF, 4);
      do_req(8,  1'b1, F3_H,  32'h0000_0012, 32'hABCD1234, 1'b0, 32'h0000_0000, 32'h123455EF, 4);
      do_req(9,  1'b0, F3_W,  32'h0000_0010, 32'h0,        1'b0, 32'h123455EF, 32'h0,        3);
      do_req(10, 1'b0, F3_H,  32'h0000_0011, 32'h0,        1'b1, 32'h0000_0000, 32'h0,        1);
      do_req(11, 1'b0, F3_W,  32'h0000_0012, 32'h0,        1'b1, 32'h0000_0000, 32'h0,        1);
      do_req(12, 1'b1, F3_W,  32'h0000_1000, 32'h12345678, 1'b1, 32'h0000_0000, 32'h0,        1);
      do_req(13, 1'b0, 3'b011, 32'h0000_0010, 32'h0,       1'b1, 32'h0000_0000, 32'h0,        1);
      do_req(14, 1'b1, F3_BU, 32'h0000_0010, 32'h0,        1'b1, 32'h0000_0000, 32'h0,        1);
      do_req(15, 1'b0, F3_HU, 32'h0000_0011, 32'h0,        1'b1, 32'h0000_0000, 32'h0,        1);
      do_req(16, 1'b1, F3_W,  32'h0000_0FFC, 32'hCAFEF00D, 1'b0, 32'h0000_0000, 32'hCAFEF00D, 2);
      do_req(17, 1'b0, F3_W,  32'h0000_0FFC, 32'h0,        1'b0, 32'hCAFEF00D, 32'h0,        3);
      do_req(18, 1'b0, F3_W,  32'h0000_0010, 32'h0,        1'b0, 32'h123455EF, 32'h0,        3);

      // aborted sub-word stores must leave word 4 untouched
      reset_during(1, F3_B, 32'h0000_0011, 32'h0000_0077, 2);
      reset_during(2, F3_H, 32'h0000_0012, 32'h0000_9999, 3);
      do_req(19, 1'b0, F3_W,  32'h0000_0010, 32'h0,        1'b0, 32'h123455EF, 32'h0,        3);

      // req_valid held high; junk requests while busy must be ignored
      b2b[0] = '{we: 1'b1, f3: F3_W,  addr: 32'h20, wdata: 32'h11223344, err: 1'b0, rdata: 32'h0,        lat: 4'd2};
      b2b[1] = '{we: 1'b0, f3: F3_W,  addr: 32'h20, wdata: 32'h0,        err: 1'b0, rdata: 32'h11223344, lat: 4'd3};
      b2b[2] = '{we: 1'b0, f3: F3_HU, addr: 32'h22, wdata: 32'h0,        err: 1'b0, rdata: 32'h00001122, lat: 4'd3};
      b2b[3] = '{we: 1'b1, f3: F3_B,  addr: 32'h20, wdata: 32'h000000AA, err: 1'b0, rdata: 32'h0,        lat: 4'd4};
      b2b[4] = '{we: 1'b0, f3: F3_H,  addr: 32'h21, wdata: 32'h0,        err: 1'b1, rdata: 32'h0,        lat: 4'd1};
      b2b[5] = '{we: 1'b0, f3: F3_B,  addr: 32'h20, wdata: 32'h0,        err: 1'b0, rdata: 32'hFFFFFFAA, lat: 4'd3};
      b2b[6] = '{we: 1'b0, f3: F3_W,  addr: 32'h20, wdata: 32'h0,        err: 1'b0, rdata: 32'h112233AA, lat: 4'd3};
      @(negedge clk);
      knext = cyc; i = 0; g = 0; guard = 0;
      while (i < 7 && guard < 200) begin
         checks++;
         if (ifc.req_ready !== (cyc == knext)) begin
            errors++;
            $display("FAIL b2b_ready cyc %0d: got %b want %b", cyc, ifc.req_ready, cyc == knext);
         end
         if (cyc == knext) begin
            drive_req(b2b[i].we, b2b[i].f3, b2b[i].addr, b2b[i].wdata);
            e.err = b2b[i].err; e.rdata = b2b[i].rdata; e.cyc = knext + int'(b2b[i].lat); e.tag = 100 + i;
            sb_q.push_back(e);
            knext = knext + int'(b2b[i].lat) + 1;
            i++;
         end else if (g == 0) begin
            drive_req(1'b1, F3_W, 32'h0000_0020, 32'hBADBAD00);
            g = 1;
         end else begin
            drive_req(1'b0, F3_W, 32'h0000_0024, 32'h0);
            g = 0;
         end
         @(negedge clk);
         guard++;
      end
      ifc.req_valid = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0 || i != 7) begin
         errors++;
         $display("FAIL b2b_drain: got %0d pending %0d issued, want 0 pending 7 issued", sb_q.size(), i);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200us");
      $fatal(1, "watchdog");
   end

endmodule
